// File: rtl/ro_puf_ctrl_pkg.sv
// Shared types and constants for the ring-oscillator PUF evaluation controller.
package ro_puf_ctrl_pkg;

  // Counter width of the RO_counter instances this controller reads back.
  localparam int unsigned CntW = 32;

  // Evaluation phases, in the order a normal challenge walks through them.
  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StClear,
    StCount,
    StStop,
    StCompare,
    StResp
  } state_e;

endpackage

// File: rtl/ro_puf_ctrl_sync_2ff.sv
// Two-flop synchroniser for level signals coming from the RO clock domains.
module ro_puf_ctrl_sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // First stage may go metastable; second stage is the only one used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/ro_puf_ctrl.sv
// RO PUF evaluation controller: selects an RO pair, clears and enables both
// counters for a fixed window, waits for both to report done, then compares the
// frozen counts and returns one response bit per challenge.
import ro_puf_ctrl_pkg::*;

module ro_puf_ctrl #(
  parameter int unsigned NUM_RO        = 16,
  parameter int unsigned SEL_W         = $clog2(NUM_RO),
  parameter int unsigned CNT_W         = CntW,
  parameter int unsigned WINDOW        = 1000,
  parameter int unsigned CLR_CYCLES    = 4,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [2*SEL_W-1:0] challenge,
  output logic               busy,
  output logic [SEL_W-1:0]   sel_a,
  output logic [SEL_W-1:0]   sel_b,
  output logic               ro_clr,
  output logic               ro_en,
  input  logic               done_a,
  input  logic               done_b,
  input  logic [CNT_W-1:0]   cnt_a,
  input  logic [CNT_W-1:0]   cnt_b,
  output logic               resp_valid,
  output logic               resp_bit,
  output logic               resp_tie,
  output logic               resp_err
);

  state_e             r_state;
  state_e             w_state_d;
  logic [31:0]        r_phase;
  logic [31:0]        w_phase_d;
  logic               r_stop_ok;
  logic               w_stop_ok_d;
  logic               w_accept;
  logic               w_err_set;

  logic [2*SEL_W-1:0] r_chal;
  logic [SEL_W-1:0]   w_idx_a;
  logic [SEL_W-1:0]   w_idx_b;

  logic [1:0]         w_done_s;
  logic               r_seen_low_a;
  logic               r_seen_low_b;
  logic               w_both_done;

  logic               r_busy;
  logic               r_clr;
  logic               r_en;
  logic               r_valid;
  logic               r_resp_bit;
  logic               r_resp_tie;
  logic               r_resp_err;

  // done_a/done_b are generated in the RO domains; nothing reads them unsynchronised.
  ro_puf_ctrl_sync_2ff #(
    .WIDTH (2)
  ) u_sync_done (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   ({done_b, done_a}),
    .o_q   (w_done_s)
  );

  assign w_idx_a = r_chal[2*SEL_W-1:SEL_W];
  assign w_idx_b = r_chal[SEL_W-1:0];

  // A done only counts once it has been seen low in this run; a stale high
  // level left over from the previous evaluation must not end STOP early.
  assign w_both_done = r_seen_low_a & r_seen_low_b & w_done_s[0] & w_done_s[1];

  // Next-state and phase-counter logic.
  always_comb begin
    w_state_d   = r_state;
    w_phase_d   = r_phase;
    w_stop_ok_d = r_stop_ok;
    w_accept    = 1'b0;
    w_err_set   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_d   = StSelect;
          w_phase_d   = '0;
          w_stop_ok_d = 1'b0;
        end
      end
      StSelect: begin
        if (w_idx_a == w_idx_b) begin
          // Comparing an RO with itself carries no information.
          w_state_d = StResp;
          w_err_set = 1'b1;
        end else if (r_phase == SETTLE_CYCLES - 1) begin
          w_state_d = StClear;
          w_phase_d = '0;
        end else begin
          w_phase_d = r_phase + 32'd1;
        end
      end
      StClear: begin
        if (r_phase == CLR_CYCLES - 1) begin
          w_state_d = StCount;
          w_phase_d = '0;
        end else begin
          w_phase_d = r_phase + 32'd1;
        end
      end
      StCount: begin
        if (r_phase == WINDOW - 1) begin
          w_state_d   = StStop;
          w_phase_d   = '0;
          w_stop_ok_d = 1'b0;
        end else begin
          w_phase_d = r_phase + 32'd1;
        end
      end
      StStop: begin
        if (!r_stop_ok) begin
          // Phase counts the timeout until both done flags are valid, then
          // restarts to count the settle period for the counter outputs.
          if (w_both_done) begin
            w_stop_ok_d = 1'b1;
            w_phase_d   = '0;
          end else if (r_phase == TIMEOUT - 1) begin
            w_state_d = StResp;
            w_err_set = 1'b1;
          end else begin
            w_phase_d = r_phase + 32'd1;
          end
        end else if (r_phase == SETTLE_CYCLES - 1) begin
          w_state_d = StCompare;
        end else begin
          w_phase_d = r_phase + 32'd1;
        end
      end
      StCompare: w_state_d = StResp;
      StResp:    w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // State register plus control outputs registered from the next state so the
  // strobes into the RO array are glitch-free and drop at once on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_phase   <= '0;
      r_stop_ok <= 1'b0;
      r_busy    <= 1'b0;
      r_clr     <= 1'b0;
      r_en      <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_phase   <= w_phase_d;
      r_stop_ok <= w_stop_ok_d;
      r_busy    <= (w_state_d != StIdle);
      r_clr     <= (w_state_d == StClear);
      r_en      <= (w_state_d == StCount);
      r_valid   <= (w_state_d == StResp);
    end
  end

  // Challenge latch, loaded only when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chal <= '0;
    end else if (w_accept) begin
      r_chal <= challenge;
    end
  end

  // Seen-low flags: proof that each counter's done was cleared during the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_low_a <= 1'b0;
      r_seen_low_b <= 1'b0;
    end else if (w_accept) begin
      r_seen_low_a <= 1'b0;
      r_seen_low_b <= 1'b0;
    end else if (r_state == StCount) begin
      if (!w_done_s[0]) r_seen_low_a <= 1'b1;
      if (!w_done_s[1]) r_seen_low_b <= 1'b1;
    end
  end

  // Response flags: cleared on accept, set in COMPARE or on error, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_bit <= 1'b0;
      r_resp_tie <= 1'b0;
      r_resp_err <= 1'b0;
    end else if (w_accept) begin
      r_resp_bit <= 1'b0;
      r_resp_tie <= 1'b0;
      r_resp_err <= 1'b0;
    end else begin
      if (r_state == StCompare) begin
        // A tie leaves resp_bit at 0 since the strict compare is false.
        r_resp_bit <= (cnt_a > cnt_b);
        r_resp_tie <= (cnt_a == cnt_b);
      end
      if (w_err_set) begin
        r_resp_err <= 1'b1;
      end
    end
  end

  assign busy       = r_busy;
  assign sel_a      = w_idx_a;
  assign sel_b      = w_idx_b;
  assign ro_clr     = r_clr;
  assign ro_en      = r_en;
  assign resp_valid = r_valid;
  assign resp_bit   = r_resp_bit;
  assign resp_tie   = r_resp_tie;
  assign resp_err   = r_resp_err;

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Self-checking bench for ro_puf_ctrl with behavioural RO counters.
module tb_ro_puf_ctrl;

  localparam int unsigned SEL_W   = 4;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned WINDOW  = 1000;
  localparam int unsigned CLR     = 4;
  localparam int unsigned SETTLE  = 4;
  localparam int unsigned TIMEOUT = 64;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic [2*SEL_W-1:0] challenge;
  logic               busy;
  logic [SEL_W-1:0]   sel_a;
  logic [SEL_W-1:0]   sel_b;
  logic               ro_clr;
  logic               ro_en;
  logic               done_a;
  logic               done_b;
  logic [CNT_W-1:0]   cnt_a;
  logic [CNT_W-1:0]   cnt_b;
  logic               resp_valid;
  logic               resp_bit;
  logic               resp_tie;
  logic               resp_err;

  ro_puf_ctrl u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .challenge  (challenge),
    .busy       (busy),
    .sel_a      (sel_a),
    .sel_b      (sel_b),
    .ro_clr     (ro_clr),
    .ro_en      (ro_en),
    .done_a     (done_a),
    .done_b     (done_b),
    .cnt_a      (cnt_a),
    .cnt_b      (cnt_b),
    .resp_valid (resp_valid),
    .resp_bit   (resp_bit),
    .resp_tie   (resp_tie),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Behavioural RO counters: clear drops done, and some RO-domain time after
  // the enable falls the final count appears and done rises.
  logic [31:0] m_cnt_a = '0;
  logic [31:0] m_cnt_b = '0;
  logic        m_done_a = 1'b1;
  logic        m_done_b = 1'b1;
  logic [31:0] tgt_a = '0;
  logic [31:0] tgt_b = '0;
  bit          stuck_b = 1'b0;
  int unsigned dly_a, dly_b;

  assign cnt_a  = m_cnt_a;
  assign cnt_b  = m_cnt_b;
  assign done_a = m_done_a;
  assign done_b = m_done_b | stuck_b;

  always @(posedge ro_clr) begin
    m_cnt_a  = '0;
    m_cnt_b  = '0;
    m_done_a = 1'b0;
    m_done_b = 1'b0;
  end

  always @(negedge ro_en) begin
    if (rst_n) begin
      dly_a = $urandom_range(3, 80);
      #(dly_a);
      m_cnt_a  = tgt_a;
      m_done_a = 1'b1;
    end
  end

  always @(negedge ro_en) begin
    if (rst_n) begin
      dly_b = $urandom_range(3, 80);
      #(dly_b);
      m_cnt_b  = tgt_b;
      m_done_b = 1'b1;
    end
  end

  // Activity monitor on the sampling edge.
  int en_cyc, clr_cyc, nresp;
  always @(negedge clk) begin
    if (rst_n) begin
      if (ro_en)      en_cyc++;
      if (ro_clr)     clr_cyc++;
      if (resp_valid) nresp++;
    end
  end

  // One full challenge against the reference rules.
  task automatic run_chal(input logic [3:0] ia, input logic [3:0] ib, input logic [31:0] ca,
                          input logic [31:0] cb, input bit stuck, input bit poke);
    bit exp_err, bad_idx, got;
    int lat;
    logic exp_bit, exp_tie;
    bad_idx = (ia == ib);
    exp_err = bad_idx || stuck;
    exp_bit = exp_err ? 1'b0 : (ca > cb);
    exp_tie = exp_err ? 1'b0 : (ca == cb);
    tgt_a   = ca;
    tgt_b   = cb;
    stuck_b = stuck;
    en_cyc  = 0;
    clr_cyc = 0;
    nresp   = 0;
    @(negedge clk);
    challenge = {ia, ib};
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    check_eq("busy_after_accept", busy, 1);
    check_eq("resp_cleared", {resp_bit, resp_tie, resp_err}, 0);
    got = 1'b0;
    while (!got && lat < 3000) begin
      if (resp_valid) begin
        got = 1'b1;
      end else begin
        if (poke && lat == 500) begin
          challenge = {ib, ia};
          start     = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    start = 1'b0;
    if (!got) begin
      check_eq("resp_timeout", 0, 1);
      return;
    end
    check_eq("resp_bit", resp_bit, exp_bit);
    check_eq("resp_tie", resp_tie, exp_tie);
    check_eq("resp_err", resp_err, exp_err);
    check_eq("sel_a", sel_a, ia);
    check_eq("sel_b", sel_b, ib);
    check_eq("busy_at_resp", busy, 1);
    check_eq("ro_en_at_resp", ro_en, 0);
    check_eq("en_cycles", en_cyc, bad_idx ? 0 : WINDOW);
    check_eq("clr_cycles", clr_cyc, bad_idx ? 0 : CLR);
    if (bad_idx)
      check_eq("lat_bad_idx", (lat <= SETTLE + 2), 1);
    else if (stuck)
      check_eq("lat_timeout", lat, SETTLE + CLR + WINDOW + TIMEOUT + 1);
    else
      check_eq("lat_normal", (lat >= SETTLE + CLR + WINDOW + SETTLE + 3) &&
                             (lat <= SETTLE + CLR + WINDOW + SETTLE + 23), 1);
    @(negedge clk);
    check_eq("busy_drop", busy, 0);
    check_eq("valid_pulse", resp_valid, 0);
    repeat (12) @(negedge clk);
    check_eq("bit_hold", resp_bit, exp_bit);
    check_eq("one_resp", nresp, 1);
  endtask

  // Reset asserted part-way through the counting window.
  task automatic reset_mid_count();
    int guard;
    tgt_a   = 32'd5210;
    tgt_b   = 32'd4980;
    stuck_b = 1'b0;
    en_cyc  = 0;
    nresp   = 0;
    @(negedge clk);
    challenge = {4'd4, 4'd11};
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (en_cyc < 300 && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
    check_eq("reach_count", (en_cyc >= 300), 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_ro_en", ro_en, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", resp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("rst_no_resp", nresp, 0);
  endtask

  initial begin
    logic [3:0]  ra, rb;
    logic [31:0] rca, rcb;
    rst_n     = 1'b0;
    start     = 1'b0;
    challenge = '0;
    #1;
    check_eq("reset_outputs",
             {busy, sel_a, sel_b, ro_clr, ro_en, resp_valid, resp_bit, resp_tie, resp_err}, 0);
    #22 rst_n = 1'b1;

    run_chal(4'd3, 4'd7, 32'd5210, 32'd4980, 1'b0, 1'b0);
    run_chal(4'd7, 4'd3, 32'd4980, 32'd5210, 1'b0, 1'b0);
    run_chal(4'd3, 4'd7, 32'd5000, 32'd5000, 1'b0, 1'b0);
    run_chal(4'd5, 4'd5, 32'd5000, 32'd4000, 1'b0, 1'b0);
    run_chal(4'd2, 4'd9, 32'd5100, 32'd4900, 1'b1, 1'b0);
    run_chal(4'd1, 4'd14, 32'd4800, 32'd5300, 1'b0, 1'b1);
    reset_mid_count();
    run_chal(4'd3, 4'd7, 32'd5210, 32'd4980, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      ra  = 4'($urandom_range(0, 15));
      rb  = 4'($urandom_range(0, 15));
      rca = $urandom_range(3000, 7000);
      rcb = ($urandom_range(0, 3) == 0) ? rca : $urandom_range(3000, 7000);
      run_chal(ra, rb, rca, rcb, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
